digital_pll_controller_v2: RTL and testbench
============================================

# digital_pll_controller_v2

Parametrised successor to the digital PLL frequency controller. Measures the DCO output (`clock`) in cycles per period of the reference `osc` and steps a trim value (`tval`) toward the ratio `div`. Adds deadband, coarse/fine stepping, hold/enable, lock detect and oscillator-loss detect. `trim` drives the ring-oscillator delay trim as a thermometer code: more ones means more delay and a slower clock.

## Interface
- `DIV_W`, 5, width of `div`; the period counter is `DIV_W+1` bits, saturating at `CNT_MAX = 2^(DIV_W+1)-1`.
- `TRIM_W`, 26, number of thermometer trim bits.
- `FRAC_W`, 2, fractional bits of `tval` below the trim LSB.
- `TVAL_W`, 7, `tval` width; must hold `TVAL_MAX = TRIM_W << FRAC_W` (default 104).
- `TVAL_INIT`, 0, `tval` value at reset.
- `DEADBAND`, 0, |err| at or below this value causes no update.
- `COARSE_THR`, 4, |err| above this value uses the coarse step.
- `COARSE_STEP`, 4, coarse step size; the fine step is 1.
- `LOCK_CNT`, 4, consecutive in-band measurements needed to assert `locked`.
- `clock`  in  1  DCO output clock; the only clock.
- `resetb`  in  1  asynchronous, active-low reset.
- `osc`  in  1  reference oscillator, asynchronous to `clock`.
- `enable`  in  1  allows `tval` updates; when 0, `tval` is frozen and `locked` is forced to 0.
- `hold`  in  1  freezes `tval`; the lock logic keeps running.
- `div`  in  DIV_W  target clock cycles per osc period.
- `trim`  out  TRIM_W  `trim[i] = (i < (tval >> FRAC_W))`, registered.
- `tval`  out  TVAL_W  current trim accumulator.
- `period`  out  DIV_W+1  last valid measurement.
- `locked`  out  1  loop-in-band indicator.
- `osc_lost`  out  1  reference absent: counter saturated.

## Operation
- Sync: `osc` passes through 2 flops (s1, s2) plus a history flop s3. A rising edge is detected in the cycle where s2=1 and s3=0.
- Counter `cnt`: on an edge cycle it loads 1; otherwise it increments, saturating at `CNT_MAX`. On an edge, the measurement is `cnt`, i.e. cycles since the previous edge.
- Validity: the first edge after reset is discarded. An edge ending a saturated count is also discarded. Both re-arm the next measurement as valid.
- osc_lost:
  - Set when `cnt` reaches `CNT_MAX`.
  - Cleared on the first valid measurement after that.
  - While it is set, `locked` is 0 and the lock counter is 0.
- Valid measurement: `period <= meas` and `err = meas - div`, computed signed at DIV_W+2 bits.
  - |err| <= `DEADBAND`: no `tval` change; lock counter increments, saturating at `LOCK_CNT`.
  - err > `DEADBAND` (clock too fast): `tval += step`.
  - err < -`DEADBAND`: `tval -= step`.
  - Any out-of-band measurement clears the lock counter.
  - step = `COARSE_STEP` if |err| > `COARSE_THR`, else 1.
  - `tval` clamps to [0, `TVAL_MAX`]; there is no wrap.
- Freezing: if `enable`=0 or `hold`=1, the `tval` update is suppressed. `period` and the lock counter still update, except that `enable`=0 holds the lock counter at 0.
- `locked` = (lock counter == `LOCK_CNT`) & `enable` & ~`osc_lost`, registered.
- `div` = 0: every measurement is out of band and `tval` ramps to `TVAL_MAX`; this is legal.
- `div` is sampled at the edge cycle; changing it between edges needs no special handling.

## Timing
- Reset values:
  - `tval` = `TVAL_INIT`; `trim` = thermometer(`TVAL_INIT`).
  - `period`, `cnt`, s1–s3, lock counter = 0.
  - `locked` = 0, `osc_lost` = 0, measurement-valid flag = 0.
- Latency: osc rise captured in s1 at edge N, so s2=1 at N+1 and the edge is detected during cycle N+1..N+2.
  - `tval`, `period` and the lock counter update at clock edge N+2.
  - `locked` and `trim` update at N+3.
- One `tval` update per osc period at most.
- Reset asserted mid-measurement returns everything to reset values immediately; the first edge after release is discarded.
- `enable` or `hold` toggling takes effect from the next edge cycle onward. An update already registered is not undone.

## Test plan
- Clock 10 ns, osc 80 ns, `div`=8, `TVAL_INIT`=0 → `period`=8, `tval` stays 0, `trim`=0, `locked`=1 after the 5th edge (1 discarded + 4 in-band).
- `div`=5 (err=+3, fine step) → `tval` +1 per osc period. After 12 valid periods `tval`=12 and `trim`=26'h7 (3 ones). `locked`=0.
- `div`=20 from `TVAL_INIT`=8 (err=-12, coarse) → `tval` goes 8→4→0 and stays 0. `trim`=0 throughout the clamp.
- `div`=1 for 40 periods → `tval` saturates at 104 and `trim` is all ones. `hold`=1 mid-ramp keeps `tval` constant while `period` keeps updating.
- Stop osc for 70 clocks → `osc_lost`=1 at `cnt`=63 and `locked` drops. On restart, the first edge is discarded, `osc_lost` clears on the second edge, and `tval` is unchanged throughout.
- Assert `resetb`=0 for 1 cycle mid-ramp at `tval`=30 → all outputs return to reset values asynchronously, with no update from the first post-reset edge.

Source files
------------

// File: rtl/digital_pll_controller_v2.sv
// Digital PLL frequency controller: measures DCO cycles per osc period
// and steps a thermometer-coded delay trim toward the target ratio.
module digital_pll_controller_v2 #(
  parameter int DIV_W       = 5,
  parameter int TRIM_W      = 26,
  parameter int FRAC_W      = 2,
  parameter int TVAL_W      = 7,
  parameter int TVAL_INIT   = 0,
  parameter int DEADBAND    = 0,
  parameter int COARSE_THR  = 4,
  parameter int COARSE_STEP = 4,
  parameter int LOCK_CNT    = 4
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              osc,
  input  logic              enable,
  input  logic              hold,
  input  logic [DIV_W-1:0]  div,
  output logic [TRIM_W-1:0] trim,
  output logic [TVAL_W-1:0] tval,
  output logic [DIV_W:0]    period,
  output logic              locked,
  output logic              osc_lost
);

  localparam int CW = DIV_W + 1;
  localparam int EW = DIV_W + 2;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int TVAL_MAX = TRIM_W << FRAC_W;

  localparam logic [CW-1:0]     CNT_MAX = '1;
  localparam logic [EW-1:0]     DB      = EW'(DEADBAND);
  localparam logic [EW-1:0]     CT      = EW'(COARSE_THR);
  localparam logic [TVAL_W:0]   STEP_C  = (TVAL_W+1)'(COARSE_STEP);
  localparam logic [TVAL_W:0]   STEP_F  = (TVAL_W+1)'(1);
  localparam logic [TVAL_W:0]   TM_W    = (TVAL_W+1)'(TVAL_MAX);
  localparam logic [TVAL_W-1:0] TM      = TVAL_W'(TVAL_MAX);
  localparam logic [TVAL_W-1:0] T_INIT  = TVAL_W'(TVAL_INIT);
  localparam logic [LW-1:0]     LK_MAX  = LW'(LOCK_CNT);

  function automatic logic [TRIM_W-1:0] therm(
    input logic [TVAL_W-1:0] v
  );
    logic [TRIM_W-1:0] t;
    logic [TVAL_W-1:0] n;
    n = v >> FRAC_W;
    for (int i = 0; i < TRIM_W; i++)
      t[i] = (i < int'(n));
    return t;
  endfunction

  logic              r_s1, r_s2, r_s3;
  logic [CW-1:0]     r_cnt;
  logic              r_vld;
  logic              r_lost;
  logic [LW-1:0]     r_lk;
  logic [TVAL_W-1:0] r_tval;
  logic [TRIM_W-1:0] r_trim;
  logic [CW-1:0]     r_period;
  logic              r_locked;

  logic              w_edge;
  logic              w_sat;
  logic              w_meas;
  logic [EW-1:0]     w_err;
  logic [EW-1:0]     w_abs;
  logic              w_inband;
  logic [TVAL_W:0]   w_step;
  logic [TVAL_W:0]   w_sum;
  logic              w_upd;
  logic [TVAL_W-1:0] w_tval;
  logic [CW-1:0]     w_cnt;
  logic              w_lost;
  logic [LW-1:0]     w_lk;

  // Edge detect, period error, trim step and next-state of the loop.
  always_comb begin
    w_edge   = r_s2 & ~r_s3;
    w_sat    = (r_cnt == CNT_MAX);
    w_meas   = w_edge & r_vld & ~w_sat;
    w_err    = $signed({1'b0, r_cnt}) - $signed({2'b00, div});
    w_abs    = w_err[EW-1] ? -w_err : w_err;
    w_inband = (w_abs <= DB);
    w_step   = (w_abs > CT) ? STEP_C : STEP_F;
    w_sum    = {1'b0, r_tval} + w_step;
    w_upd    = w_meas & enable & ~hold & ~w_inband;
    w_tval   = r_tval;
    if (w_upd) begin
      if (!w_err[EW-1])
        w_tval = (w_sum > TM_W) ? TM : w_sum[TVAL_W-1:0];
      else if ({1'b0, r_tval} < w_step)
        w_tval = '0;
      else
        w_tval = r_tval - w_step[TVAL_W-1:0];
    end
    if (w_edge)
      w_cnt = CW'(1);
    else if (w_sat)
      w_cnt = CNT_MAX;
    else
      w_cnt = r_cnt + CW'(1);
    w_lost = r_lost;
    if (w_meas)
      w_lost = 1'b0;
    else if (w_cnt == CNT_MAX)
      w_lost = 1'b1;
    w_lk = r_lk;
    if (w_meas) begin
      if (w_inband & enable)
        w_lk = (r_lk == LK_MAX) ? r_lk : r_lk + LW'(1);
      else
        w_lk = '0;
    end else if (r_lost) begin
      w_lk = '0;
    end
  end

  // Loop state registers; first edge after reset only arms measuring.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_cnt    <= '0;
      r_vld    <= 1'b0;
      r_lost   <= 1'b0;
      r_lk     <= '0;
      r_tval   <= T_INIT;
      r_trim   <= therm(T_INIT);
      r_period <= '0;
      r_locked <= 1'b0;
    end else begin
      r_s1     <= osc;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_cnt    <= w_cnt;
      r_vld    <= r_vld | w_edge;
      r_lost   <= w_lost;
      r_lk     <= w_lk;
      r_tval   <= w_tval;
      r_trim   <= therm(r_tval);
      if (w_meas)
        r_period <= r_cnt;
      r_locked <= (r_lk == LK_MAX) & enable & ~r_lost;
    end
  end

  assign trim     = r_trim;
  assign tval     = r_tval;
  assign period   = r_period;
  assign locked   = r_locked;
  assign osc_lost = r_lost;

endmodule

// File: tb/tb_digital_pll_controller_v2.sv
// Bench for digital_pll_controller_v2: directed vector table plus
// randomized osc/div/enable/hold against an event-level reference model.
module tb_digital_pll_controller_v2;

  logic        clock = 1'b0;
  logic        resetb;
  logic        osc;
  logic        enable;
  logic        hold;
  logic [4:0]  div;
  logic [25:0] trim;
  logic [6:0]  tval;
  logic [5:0]  period;
  logic        locked;
  logic        osc_lost;

  always #5 clock = ~clock;

  digital_pll_controller_v2 dut (
    .clock    (clock),
    .resetb   (resetb),
    .osc      (osc),
    .enable   (enable),
    .hold     (hold),
    .div      (div),
    .trim     (trim),
    .tval     (tval),
    .period   (period),
    .locked   (locked),
    .osc_lost (osc_lost)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: cycles counted since the last measurement
  // started; rising osc samples schedule a measurement two clocks on.
  int m_t, m_base, m_prev;
  bit m_armed;
  int q[$];
  int m_tval, m_period, m_lk;
  bit m_lost, m_locked;
  logic [25:0] m_trim;

  function automatic logic [25:0] therm_ref(input int v);
    logic [63:0] one;
    one = 64'd1;
    return 26'((one << (v / 4)) - 64'd1);
  endfunction

  task automatic model_reset();
    m_t = 0; m_base = 0; m_prev = 0; m_armed = 0;
    q.delete();
    m_tval = 0; m_period = 0; m_lk = 0;
    m_lost = 0; m_locked = 0; m_trim = '0;
  endtask

  task automatic model_posedge();
    int t, cb, ca, meas, err, ae, stp, nt;
    int n_tval, n_lk, n_period;
    bit n_lost, apply, ok;
    t  = m_t + 1;
    cb = (m_t - m_base > 63) ? 63 : m_t - m_base;
    apply = (q.size() > 0) && (q[0] == t);
    if (apply) void'(q.pop_front());
    n_tval = m_tval; n_lk = m_lk;
    n_period = m_period; n_lost = m_lost;
    if (apply) begin
      ok = m_armed && (cb != 63);
      m_armed = 1;
      m_base = t - 1;
      if (ok) begin
        meas = cb;
        err = meas - int'(div);
        ae = (err < 0) ? -err : err;
        n_period = meas;
        n_lost = 0;
        n_lk = (ae == 0 && enable) ?
               ((m_lk + 1 > 4) ? 4 : m_lk + 1) : 0;
        if (ae != 0 && enable && !hold) begin
          stp = (ae > 4) ? 4 : 1;
          nt = (err > 0) ? m_tval + stp : m_tval - stp;
          n_tval = (nt < 0) ? 0 : (nt > 104) ? 104 : nt;
        end
      end else if (m_lost) begin
        n_lk = 0;
      end
    end else begin
      if (m_lost) n_lk = 0;
      ca = (t - m_base > 63) ? 63 : t - m_base;
      if (ca == 63) n_lost = 1;
    end
    m_locked = (m_lk == 4) && enable && !m_lost;
    m_trim = therm_ref(m_tval);
    m_tval = n_tval; m_lk = n_lk;
    m_period = n_period; m_lost = n_lost;
    if (osc && m_prev == 0) q.push_back(t + 2);
    m_prev = int'(osc);
    m_t = t;
  endtask

  task automatic check_model();
    chk("m_tval",   32'(tval),     32'(m_tval));
    chk("m_trim",   32'(trim),     32'(m_trim));
    chk("m_period", 32'(period),   32'(m_period));
    chk("m_locked", 32'(locked),   32'(m_locked));
    chk("m_lost",   32'(osc_lost), 32'(m_lost));
  endtask

  // Called at a falling edge: drive osc, clock once, compare.
  task automatic step_cycle(input logic o);
    osc = o;
    @(posedge clock);
    if (resetb) model_posedge();
    @(negedge clock);
    check_model();
  endtask

  task automatic run_seg(input int per, input int n);
    if (per == 0) begin
      repeat (n) step_cycle(1'b0);
    end else begin
      for (int p = 0; p < n; p++)
        for (int ph = 0; ph < per; ph++)
          step_cycle(ph < (per + 1) / 2);
    end
  endtask

  task automatic pulse_reset(input int n);
    resetb = 1'b0;
    model_reset();
    #1;
    chk("rst tval",   32'(tval),     32'd0);
    chk("rst trim",   32'(trim),     32'd0);
    chk("rst period", 32'(period),   32'd0);
    chk("rst locked", 32'(locked),   32'd0);
    chk("rst lost",   32'(osc_lost), 32'd0);
    repeat (n) @(negedge clock);
    resetb = 1'b1;
  endtask

  typedef struct {
    int en; int hd; int dv; int per; int n;
    int e_tval; int e_period; int e_locked; int e_lost;
    logic [25:0] e_trim;
  } vec_t;

  vec_t v[11];

  initial begin
    v[0]  = '{1, 0, 8,  8, 6,    0, 8, 1, 0, 26'h0};
    v[1]  = '{1, 0, 5,  8, 12,  12, 8, 0, 0, 26'h7};
    v[2]  = '{1, 0, 20, 8, 4,    0, 8, 0, 0, 26'h0};
    v[3]  = '{1, 0, 1,  8, 10,  40, 8, 0, 0, 26'h3FF};
    v[4]  = '{1, 1, 1,  6, 5,   40, 6, 0, 0, 26'h3FF};
    v[5]  = '{1, 0, 1,  8, 20, 104, 8, 0, 0, 26'h3FFFFFF};
    v[6]  = '{0, 0, 20, 8, 4,  104, 8, 0, 0, 26'h3FFFFFF};
    v[7]  = '{1, 0, 8,  8, 6,  104, 8, 1, 0, 26'h3FFFFFF};
    v[8]  = '{1, 0, 8,  0, 70, 104, 8, 0, 1, 26'h3FFFFFF};
    v[9]  = '{1, 0, 8,  8, 1,  104, 8, 0, 1, 26'h3FFFFFF};
    v[10] = '{1, 0, 8,  8, 1,  104, 8, 0, 0, 26'h3FFFFFF};

    resetb = 1'b0; osc = 1'b0;
    enable = 1'b1; hold = 1'b0; div = 5'd8;
    model_reset();
    @(negedge clock);
    pulse_reset(3);

    for (int i = 0; i < 11; i++) begin
      enable = v[i].en[0];
      hold   = v[i].hd[0];
      div    = 5'(v[i].dv);
      run_seg(v[i].per, v[i].n);
      chk($sformatf("vec%0d tval", i),   32'(tval),   32'(v[i].e_tval));
      chk($sformatf("vec%0d period", i), 32'(period), 32'(v[i].e_period));
      chk($sformatf("vec%0d locked", i), 32'(locked), 32'(v[i].e_locked));
      chk($sformatf("vec%0d lost", i),   32'(osc_lost), 32'(v[i].e_lost));
      chk($sformatf("vec%0d trim", i),   32'(trim),   32'(v[i].e_trim));
    end

    // Reset mid-ramp at tval=30, then discard the first edge.
    pulse_reset(1);
    enable = 1'b1; hold = 1'b0; div = 5'd5;
    run_seg(8, 31);
    chk("ramp30 tval", 32'(tval), 32'd30);
    step_cycle(1'b1);
    pulse_reset(1);
    run_seg(8, 1);
    chk("post-rst tval",   32'(tval),   32'd0);
    chk("post-rst period", 32'(period), 32'd0);
    run_seg(8, 1);
    chk("post-rst2 tval",   32'(tval),   32'd1);
    chk("post-rst2 period", 32'(period), 32'd8);

    // Randomized segments checked cycle by cycle against the model.
    for (int s = 0; s < 80; s++) begin
      div    = 5'($urandom_range(31, 0));
      enable = ($urandom_range(7, 0) != 0);
      hold   = ($urandom_range(5, 0) == 0);
      if ($urandom_range(14, 0) == 0)
        pulse_reset($urandom_range(3, 1));
      if ($urandom_range(12, 0) == 0)
        run_seg(0, $urandom_range(90, 40));
      else
        run_seg($urandom_range(20, 2), $urandom_range(8, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
